// File: rtl/delta_sigma_mc.sv
// delta_sigma_mc: multi-channel PWM-dither / first-order sigma-delta audio DAC modulator.
// Optional build macro DS_UNDERRUN_MUTE_EN: an underrun forces midscale instead of holding the last sample.
module delta_sigma_mc #(
   parameter int INBITS   = 16,
   parameter int OUTBITS  = 4,
   parameter int CHANNELS = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode_i,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [CHANNELS*INBITS-1:0]   s_data,
   output logic [CHANNELS*OUTBITS-1:0]  audio_o,
   output logic                         frame_o,
   output logic                         underrun_o
);
   localparam int FRAC = INBITS - OUTBITS;
`ifdef DS_UNDERRUN_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif
   localparam logic [CHANNELS*INBITS-1:0] MID = {CHANNELS{1'b1, {(INBITS-1){1'b0}}}};

   logic [FRAC-1:0]              cnt_q;
   logic                         pend_full_q, mode_q, frame_q, under_q;
   logic [CHANNELS*INBITS-1:0]   pend_q, act_q, act_d;
   logic [CHANNELS*FRAC-1:0]     acc_q, acc_d;
   logic [CHANNELS*OUTBITS-1:0]  audio_q, audio_d;
   logic                         wrap, accept, underrun, clr;

   assign wrap     = &cnt_q;
   assign s_ready  = !pend_full_q | wrap;
   assign accept   = s_valid & s_ready;
   assign underrun = wrap & !pend_full_q & !accept;
   // accumulators restart on a mode switch so the new mode starts from a clean phase
   assign clr      = (wrap & (mode_i != mode_q)) | (MUTE & underrun);
   assign act_d    = (wrap & pend_full_q) ? pend_q : (MUTE & underrun) ? MID : act_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [OUTBITS-1:0] hi, pwm, sd;
      logic [FRAC-1:0]    lo;
      logic [FRAC:0]      sum;
      logic               top;
      assign hi  = act_q[c*INBITS+FRAC +: OUTBITS];
      assign lo  = act_q[c*INBITS +: FRAC];
      assign top = &hi;
      assign sum = {1'b0, acc_q[c*FRAC +: FRAC]} + {1'b0, lo};
      assign pwm = (lo > cnt_q && !top) ? hi + 1'b1 : hi;
      assign sd  = top ? hi : hi + {{(OUTBITS-1){1'b0}}, sum[FRAC]};
      assign audio_d[c*OUTBITS +: OUTBITS] = mode_q ? sd : pwm;
      assign acc_d[c*FRAC +: FRAC] = clr ? '0 : sum[FRAC-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         pend_full_q <= 1'b0;
         pend_q      <= '0;
         act_q       <= '0;
         acc_q       <= '0;
         audio_q     <= '0;
         mode_q      <= 1'b0;
         frame_q     <= 1'b0;
         under_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_q + 1'b1;
         pend_full_q <= accept | (pend_full_q & !wrap);
         if (accept) pend_q <= s_data;
         act_q       <= act_d;
         acc_q       <= acc_d;
         audio_q     <= audio_d;
         if (wrap) mode_q <= mode_i;
         frame_q     <= wrap;
         under_q     <= underrun;
      end
   end

   assign audio_o    = audio_q;
   assign frame_o    = frame_q;
   assign underrun_o = under_q;
endmodule

// File: tb/tb_delta_sigma_mc.sv
// tb_delta_sigma_mc: directed checks of handshake, PWM, sigma-delta, saturation, underrun and reset.
module tb_delta_sigma_mc;
   logic        clk = 1'b0, rst_n = 1'b1, mode_i = 1'b0, s_valid = 1'b0;
   logic        s_ready, frame_o, underrun_o;
   logic [31:0] s_data = '0;
   logic [7:0]  audio_o;
   logic [3:0]  a0, a1, prev, first;
   int          n_chk = 0, n_fail = 0;
   int          n2, n1, nz, bad, alt, sum, k;
`ifdef DS_UNDERRUN_MUTE_EN
   localparam logic [3:0] U0 = 4'd8, U1 = 4'd8, R0 = 4'd8;
`else
   localparam logic [3:0] U0 = 4'd15, U1 = 4'd0, R0 = 4'd0;
`endif

   always #5 clk = ~clk;
   assign a0 = audio_o[3:0];
   assign a1 = audio_o[7:4];

   delta_sigma_mc dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .audio_o(audio_o), .frame_o(frame_o), .underrun_o(underrun_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d);
      s_data  = d;
      s_valid = 1'b1;
      chk("send_ready", s_ready, 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic sync_frame(input string tag);
      int j = 0;
      do begin
         @(negedge clk);
         j++;
      end while (!frame_o && j < 5000);
      chk(tag, frame_o, 1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_audio", audio_o, 0);
      chk("rst_frame", frame_o, 0);
      chk("rst_under", underrun_o, 0);
      rst_n = 1'b1;
      #1 chk("rst_ready", s_ready, 1);
      send({16'h0000, 16'h1234});
      chk("busy_after_A", s_ready, 0);
      sync_frame("frame_A");
      chk("under_A", underrun_o, 0);
      // period 1: PWM on 0x1234
      mode_i = 1'b1;
      send({16'h0000, 16'h1800});
      n2 = 0; n1 = 0; nz = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (a0 == 4'd2) n2++;
         else if (a0 == 4'd1) n1++;
         if (a1 != 4'd0) nz++;
      end
      chk("pwm_cnt2", n2, 564);
      chk("pwm_cnt1", n1, 3532);
      chk("pwm_ch1", nz, 0);
      chk("frame_p1", frame_o, 1);
      chk("under_p1", underrun_o, 0);
      // period 2: sigma-delta on 0x1800
      send({16'h0000, 16'hFFFF});
      sum = 0; alt = 0; nz = 0; prev = '0; first = '0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (i == 0) first = a0;
         else if (a0 == prev) alt++;
         prev = a0;
         sum += int'(a0);
         if (a1 != 4'd0) nz++;
      end
      chk("sd_first", first, 1);
      chk("sd_alt", alt, 0);
      chk("sd_sum", sum, 6144);
      chk("sd_ch1", nz, 0);
      // period 3: saturation in sigma-delta
      send({16'h0000, 16'hFFFF});
      mode_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (a0 != 4'd15) bad++;
      end
      chk("sat_sd", bad, 0);
      // period 4: saturation in PWM, nothing queued
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (a0 != 4'd15) bad++;
      end
      chk("sat_pwm", bad, 0);
      chk("frame_p4", frame_o, 1);
      chk("under_p4", underrun_o, 1);
      @(negedge clk);
      chk("under_pulse", underrun_o, 0);
      chk("under_ch0", a0, U0);
      chk("under_ch1", a1, U1);
      bad = 0;
      repeat (98) begin
         @(negedge clk);
         if (a0 != U0 || a1 != U1) bad++;
      end
      chk("under_hold", bad, 0);
      // back-to-back words mid-period
      send({16'h0000, 16'h4000});
      s_data  = {16'h0000, 16'h7000};
      s_valid = 1'b1;
      @(negedge clk);
      chk("b2b_busy", s_ready, 0);
      k = 0; bad = 0;
      while (!s_ready && k < 5000) begin
         @(negedge clk);
         k++;
         if (a0 != U0) bad++;
      end
      chk("b2b_wrap_ready", s_ready, 1);
      chk("b2b_hold", bad, 0);
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      chk("b2b_frame", frame_o, 1);
      chk("b2b_under", underrun_o, 0);
      chk("b2b_pend", s_ready, 0);
      chk("b2b_old", a0, U0);
      @(negedge clk);
      chk("b2b_w1", a0, 4);
      sync_frame("frame_w2");
      chk("b2b_w1_end", a0, 4);
      @(negedge clk);
      chk("b2b_w2", a0, 7);
      // reset mid-period with a pending word
      send({16'h0000, 16'h2000});
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_audio", audio_o, 0);
      chk("mid_rst_frame", frame_o, 0);
      chk("mid_rst_under", underrun_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mid_rst_ready", s_ready, 1);
      sync_frame("frame_rst");
      chk("rst_discard_under", underrun_o, 1);
      chk("rst_discard_audio", a0, 0);
      @(negedge clk);
      chk("rst_after", a0, R0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
